axis_pulse_gen: RTL
===================

# axis_pulse_gen

Generates a repeating trapezoidal pulse waveform as an AXI4-Stream sample stream for the DAC path. Each period has five segments: pre-offset baseline, linear ramp up, flat top, linear ramp down and post-offset baseline. It is the stimulus side of the pulse-measurement chain, and its segment lengths use the same pre_offset/ramp/width/post_offset encoding as the pulse measurement core. The generator's output can therefore be looped back and measured with one shared configuration word.

## Interface
Parameters:
- AXIS_TDATA_WIDTH, 16, sample width, two's complement
- PULSE_WIDTH, 16, width of each segment-length field
- CNTR_WIDTH, 32, width of the internal sample and period counters

Ports:
- aclk  in  1  system clock; single clock domain
- areset  in  1  synchronous, active-high reset
- cfg_data  in  PULSE_WIDTH*4+AXIS_TDATA_WIDTH*3+32  fields from LSB upward:
  - pre_offset, ramp, width, post_offset (PULSE_WIDTH each, unsigned)
  - baseline (signed)
  - amplitude (signed)
  - ramp_step (unsigned)
  - pulse_count (32 bits)
- enable  in  1  level; high requests generation
- busy  out  1  high while a period is in progress
- gate  out  1  high while the flat-top beat is presented on the output
- sts_data  out  32  completed-period counter; wraps modulo 2^32; cleared at each start from IDLE
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  AXIS_TDATA_WIDTH  sample
- m_axis_tvalid  out  1  sample valid
- m_axis_tlast  out  1  last beat of a period

## Operation
- State machine states: IDLE, PRE, RAMP_UP, TOP, RAMP_DN, POST.
- Segment lengths: PRE=pre_offset, RAMP_UP=ramp, TOP=width, RAMP_DN=ramp, POST=post_offset.
- A segment of length N emits exactly N beats.
- The segment counter advances only on a handshake (tvalid & tready).
- The state changes on the handshake of a segment's last beat.
- Zero-length segments are skipped: next-state logic selects the next nonzero segment in order.
- If all four lengths are zero, the block stays in IDLE regardless of enable.
- Starting a run:
  - In IDLE with enable=1, latch cfg_data into shadow registers.
  - Clear sts_data and the period counter.
  - Enter the first nonzero segment.
- At the end of each period:
  - Increment sts_data.
  - If enable=1 and (pulse_count==0 or periods done < pulse_count): re-latch cfg_data and start the next period immediately, with no idle beat.
  - Otherwise go to IDLE.
- Deasserting enable mid-period never truncates the period; the current period completes with tlast.
- cfg_data changes take effect only at a period boundary.
- Sample values:
  - PRE and POST: baseline.
  - TOP: amplitude.
  - RAMP_UP: the first beat is baseline+ramp_step; each further beat adds ramp_step. The value saturates at amplitude.
  - RAMP_DN: the first beat is amplitude−ramp_step; each further beat subtracts ramp_step. The value saturates at baseline.
- Arithmetic width and saturation:
  - Computed at AXIS_TDATA_WIDTH+2 bits signed; ramp_step is zero-extended.
  - The result is also clamped to the signed AXIS_TDATA_WIDTH range.
  - The configuration requires amplitude ≥ baseline.
  - If amplitude < baseline, the ramps output baseline on every beat.
- m_axis_tlast is high on the final beat of the final nonzero segment of every period.
- gate is high exactly on beats where the state is TOP.

## Timing
- Reset values of all outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, gate=0, sts_data=0.
- Reset asserted mid-period: outputs return to reset values on the next rising edge; no partial period is resumed.
- All outputs are registered.
- Latency from start:
  - enable is sampled high in IDLE at edge k.
  - tvalid=1 and the first beat are presented after edge k (visible cycle k+1).
  - busy rises on the same edge.
- AXIS handshake rules:
  - tdata, tlast and gate hold stable while tvalid=1 and tready=0.
  - Once asserted, tvalid is deasserted only after the handshake of the final tlast beat when returning to IDLE.
- Throughput is one beat per cycle when tready is held high, including across period boundaries.
- busy falls on the same edge that drops tvalid.
- sts_data increments on the edge that accepts the tlast beat.

## Test plan
- Nominal period, tready=1, one period:
  - Config: pre=2, ramp=3, width=4, post=2, baseline=−100, amplitude=500, step=250, pulse_count=1, enable high one cycle.
  - Required 14 beats: −100,−100,150,400,500,500,500,500,500,250,0,−100,−100,−100.
  - tlast only on beat 14; gate high on beats 6–9; sts_data=1; then IDLE.
- Backpressure:
  - Same config, tready toggled on a pseudo-random pattern.
  - Identical beat sequence; tdata, tlast and gate stable while stalled; no beats dropped or duplicated.
- Zero-length segments:
  - Config: pre=0, ramp=0, width=3, post=0, pulse_count=2.
  - Required: 6 beats of amplitude, tlast on beats 3 and 6, no gap between periods, sts_data=2.
  - With all four lengths zero and enable=1: tvalid stays 0.
- Continuous mode and config tearing:
  - Config: pulse_count=0, enable high; change amplitude mid-period.
  - Required: the new amplitude appears only after the next tlast.
  - Drop enable mid-TOP: the period completes through POST with tlast, then tvalid=0.
- Saturation:
  - Config: baseline=32000, amplitude=32767, step=65535, ramp=2.
  - Required: ramp-up beats are 32767,32767; ramp-down beats are 32000,32000; no wrap.
- Reset mid-RAMP_UP:
  - Required: tvalid=0, sts_data=0 and busy=0 on the next edge.
  - With enable held, the next period starts from PRE with the first beat = baseline.

Source files
------------

// File: rtl/axis_pulse_gen.sv
// rtl/axis_pulse_gen.sv - trapezoidal pulse generator emitting an AXI4-Stream sample stream
// Five segments per period (pre, ramp up, top, ramp down, post); config is shadowed at period boundaries.
module axis_pulse_gen #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int PULSE_WIDTH      = 16,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                                           aclk,
    input  logic                                           areset,
    input  logic [PULSE_WIDTH*4+AXIS_TDATA_WIDTH*3+32-1:0] cfg_data,
    input  logic                                           enable,
    output logic                                           busy,
    output logic                                           gate,
    output logic [31:0]                                    sts_data,
    input  logic                                           m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]                    m_axis_tdata,
    output logic                                           m_axis_tvalid,
    output logic                                           m_axis_tlast
);

    localparam int PW = PULSE_WIDTH;
    localparam int DW = AXIS_TDATA_WIDTH;
    localparam int AW = AXIS_TDATA_WIDTH + 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRE     = 3'd1;
    localparam logic [2:0] S_RAMP_UP = 3'd2;
    localparam logic [2:0] S_TOP     = 3'd3;
    localparam logic [2:0] S_RAMP_DN = 3'd4;
    localparam logic [2:0] S_POST    = 3'd5;

    localparam logic signed [AW-1:0] MAX_V = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {3'b111, {(DW-1){1'b0}}};

    typedef struct packed {
        logic [31:0]   pulse_count;
        logic [DW-1:0] ramp_step;
        logic [DW-1:0] amplitude;
        logic [DW-1:0] baseline;
        logic [PW-1:0] post_offset;
        logic [PW-1:0] width;
        logic [PW-1:0] ramp;
        logic [PW-1:0] pre_offset;
    } cfg_t;

    function automatic logic [PW-1:0] seg_len(input logic [2:0] s, input cfg_t c);
        logic [PW-1:0] r;
        case (s)
            S_PRE:              r = c.pre_offset;
            S_RAMP_UP, S_RAMP_DN: r = c.ramp;
            S_TOP:              r = c.width;
            S_POST:             r = c.post_offset;
            default:            r = '0;
        endcase
        return r;
    endfunction

    // First nonzero segment strictly after s; S_IDLE means the period is over.
    function automatic logic [2:0] next_seg(input logic [2:0] s, input cfg_t c);
        logic [2:0] r;
        r = S_IDLE;
        if (s < S_POST    && c.post_offset != '0) r = S_POST;
        if (s < S_RAMP_DN && c.ramp        != '0) r = S_RAMP_DN;
        if (s < S_TOP     && c.width       != '0) r = S_TOP;
        if (s < S_RAMP_UP && c.ramp        != '0) r = S_RAMP_UP;
        if (s < S_PRE     && c.pre_offset  != '0) r = S_PRE;
        return r;
    endfunction

    cfg_t                   shadow_q, shadow_d, sel_cfg, cfg_in;
    logic [2:0]             state_q, state_d, seg_after;
    logic [CNTR_WIDTH-1:0]  idx_q, idx_d, period_q, period_d, period_inc;
    logic                   seg_last_q, seg_last_d;
    logic [31:0]            sts_q, sts_d;
    logic                   tvalid_q, tvalid_d, tlast_q, tlast_d, gate_q, gate_d, busy_q, busy_d;
    logic [DW-1:0]          tdata_q, tdata_d;
    logic                   handshake, cfg_nonzero, reload, emit;
    logic signed [AW-1:0]   base_x, amp_x, step_x, prev_x, val;

    assign cfg_in      = cfg_data;
    assign handshake   = tvalid_q & m_axis_tready;
    assign cfg_nonzero = |{cfg_in.pre_offset, cfg_in.ramp, cfg_in.width, cfg_in.post_offset};
    assign seg_after   = next_seg(state_q, shadow_q);
    assign period_inc  = period_q + CNTR_WIDTH'(1);

    always_comb begin
        shadow_d   = shadow_q;
        state_d    = state_q;
        idx_d      = idx_q;
        period_d   = period_q;
        sts_d      = sts_q;
        seg_last_d = seg_last_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        gate_d     = gate_q;
        busy_d     = busy_q;
        tdata_d    = tdata_q;
        reload     = 1'b0;
        emit       = 1'b0;
        sel_cfg    = shadow_q;
        base_x     = '0;
        amp_x      = '0;
        step_x     = '0;
        prev_x     = '0;
        val        = '0;

        if (state_q == S_IDLE) begin
            if (enable && cfg_nonzero) begin
                reload   = 1'b1;
                sts_d    = '0;
                period_d = '0;
            end
        end else if (handshake) begin
            if (!seg_last_q) begin
                emit  = 1'b1;
                idx_d = idx_q + CNTR_WIDTH'(1);
            end else if (seg_after != S_IDLE) begin
                emit    = 1'b1;
                state_d = seg_after;
                idx_d   = '0;
            end else begin
                sts_d    = sts_q + 32'd1;
                period_d = period_inc;
                if (enable && cfg_nonzero &&
                    (shadow_q.pulse_count == 32'd0 ||
                     period_inc < CNTR_WIDTH'(shadow_q.pulse_count))) begin
                    reload = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    idx_d      = '0;
                    seg_last_d = 1'b0;
                    tvalid_d   = 1'b0;
                    tlast_d    = 1'b0;
                    gate_d     = 1'b0;
                    busy_d     = 1'b0;
                    tdata_d    = '0;
                end
            end
        end

        if (reload) begin
            shadow_d = cfg_in;
            sel_cfg  = cfg_in;
            state_d  = next_seg(S_IDLE, cfg_in);
            idx_d    = '0;
            emit     = 1'b1;
        end

        if (emit) begin
            base_x = {{2{sel_cfg.baseline[DW-1]}}, sel_cfg.baseline};
            amp_x  = {{2{sel_cfg.amplitude[DW-1]}}, sel_cfg.amplitude};
            step_x = {2'b00, sel_cfg.ramp_step};
            prev_x = {{2{tdata_q[DW-1]}}, tdata_q};
            // Ramps build on the previous beat; the first ramp beat starts from the segment's anchor.
            case (state_d)
                S_TOP: val = amp_x;
                S_RAMP_UP: begin
                    val = ((idx_d == '0) ? base_x : prev_x) + step_x;
                    if (amp_x < base_x)   val = base_x;
                    else if (val > amp_x) val = amp_x;
                end
                S_RAMP_DN: begin
                    val = ((idx_d == '0) ? amp_x : prev_x) - step_x;
                    if (amp_x < base_x)    val = base_x;
                    else if (val < base_x) val = base_x;
                end
                default: val = base_x;
            endcase
            if (val > MAX_V)      val = MAX_V;
            else if (val < MIN_V) val = MIN_V;

            tvalid_d   = 1'b1;
            busy_d     = 1'b1;
            gate_d     = (state_d == S_TOP);
            seg_last_d = (idx_d == CNTR_WIDTH'(seg_len(state_d, sel_cfg)) - CNTR_WIDTH'(1));
            tlast_d    = seg_last_d && (next_seg(state_d, sel_cfg) == S_IDLE);
            tdata_d    = val[DW-1:0];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            shadow_q   <= '0;
            state_q    <= S_IDLE;
            idx_q      <= '0;
            period_q   <= '0;
            sts_q      <= '0;
            seg_last_q <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            tdata_q    <= '0;
        end else begin
            shadow_q   <= shadow_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            period_q   <= period_d;
            sts_q      <= sts_d;
            seg_last_q <= seg_last_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            gate_q     <= gate_d;
            busy_q     <= busy_d;
            tdata_q    <= tdata_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign gate          = gate_q;
    assign busy          = busy_q;
    assign sts_data      = sts_q;

endmodule
